// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the fetch stage.
package mips_pkg;
    localparam int          INSTR_W            = 32;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter with synchronous reset and load enable.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else if (en_i) pc_q <= d_i;
    end

    assign q_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC selection and IF/ID pipeline register.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets to EXC_VECTOR.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               misalign_exc
);
    logic [31:0]        pc_q, pc_d, pc4, target;
    logic               redirect;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               valid_q, valid_d;

    assign pc4      = pc_q + 32'h4;
    assign redirect = branch_taken | jump;
    // The branch is older than the jump, so it wins when both resolve together.
    assign target   = branch_taken ? branch_target : jump_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic exc_q;
    logic misaligned;

    assign misaligned = redirect & (|target[1:0]);
    assign pc_d       = misaligned ? EXC_VECTOR : redirect ? target : pc4;

    always_ff @(posedge clk) begin
        if (rst) exc_q <= 1'b0;
        else if (misaligned) exc_q <= 1'b1;
    end

    assign misalign_exc = exc_q;
`else
    logic unused_exc_vector;

    assign unused_exc_vector = ^EXC_VECTOR;
    assign pc_d              = redirect ? target : pc4;
    assign misalign_exc      = 1'b0;
`endif

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (redirect | ~stall),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    always_comb begin
        instr_d = redirect ? NOP_INSTR : stall ? instr_q : imem_rdata;
        pc4_d   = redirect ? 32'h0 : stall ? pc4_q : pc4;
        valid_d = redirect ? 1'b0 : stall ? valid_q : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
    logic        if_id_valid, misalign_exc;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .misalign_exc  (misalign_exc)
    );

    always #5 clk = ~clk;
    assign imem_rdata = 32'hA0 + imem_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic j,
                        input logic [31:0] bt, input logic [31:0] jt,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid, input logic e_exc);
        exp_t e;
        exp_q.push_back('{e_addr, e_instr, e_pc4, e_valid, e_exc});
        rst = r; stall = s; branch_taken = b; jump = j;
        branch_target = bt; jump_target = jt;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("misalign_exc", {31'b0, misalign_exc}, {31'b0, e.exc});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mis_addr;
        logic        mis_exc;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_addr = 32'h8000_0180;
        mis_exc  = 1'b1;
`else
        mis_addr = 32'h0000_0102;
        mis_exc  = 1'b0;
`endif
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        @(negedge clk);
        // reset state
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        // free-running fetch from RESET_PC
        step(0, 0, 0, 0, 0, 0, 32'h4,  32'hA0, 32'h4,  1, 0);
        step(0, 0, 0, 0, 0, 0, 32'h8,  32'hA4, 32'h8,  1, 0);
        step(0, 0, 0, 0, 0, 0, 32'hC,  32'hA8, 32'hC,  1, 0);
        step(0, 0, 0, 0, 0, 0, 32'h10, 32'hAC, 32'h10, 1, 0);
        // stall held 3 cycles at PC 0x10
        step(0, 1, 0, 0, 0, 0, 32'h10, 32'hAC, 32'h10, 1, 0);
        step(0, 1, 0, 0, 0, 0, 32'h10, 32'hAC, 32'h10, 1, 0);
        step(0, 1, 0, 0, 0, 0, 32'h10, 32'hAC, 32'h10, 1, 0);
        step(0, 0, 0, 0, 0, 0, 32'h14, 32'hB0, 32'h14, 1, 0);
        step(0, 0, 0, 0, 0, 0, 32'h18, 32'hB4, 32'h18, 1, 0);
        // branch + jump + stall: branch wins, flush
        step(0, 1, 1, 1, 32'h200, 32'h300, 32'h200, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h204, 32'h2A0, 32'h204, 1, 0);
        // jump to top of address space, then wrap
        step(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h9C, 32'h0, 1, 0);
        // misaligned jump target
        step(0, 0, 0, 1, 0, 32'h102, mis_addr, 32'h0, 32'h0, 0, mis_exc);
        step(0, 0, 0, 0, 0, 0, mis_addr + 32'h4, mis_addr + 32'hA0, mis_addr + 32'h4, 1, mis_exc);
        // branch alone, then jump beating a stall, then plain stall on a bubble
        step(0, 0, 1, 0, 32'h40, 32'h0, 32'h40, 32'h0, 32'h0, 0, mis_exc);
        step(0, 1, 0, 1, 32'h0, 32'h80, 32'h80, 32'h0, 32'h0, 0, mis_exc);
        step(0, 1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0, 0, mis_exc);
        step(0, 0, 0, 0, 0, 0, 32'h84, 32'h120, 32'h84, 1, mis_exc);
        // reset during stall and branch
        step(1, 1, 1, 0, 32'h500, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h4, 32'hA0, 32'h4, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
